// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges hazard, redirect, fetch and data-memory status into per-stage holds.
module pipe_stall_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int TO_WIDTH    = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_use_hazard,
    input  logic                 br_taken,
    input  logic                 imem_valid,
    input  logic                 dmem_busy,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_flush,
    output logic                 ex_mem_write,
    output logic                 mem_wb_flush,
    output logic                 fetch_kill,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        REDIR_KILL = 2'd2
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                kill_pending;
    logic                kill_pending_nxt;
    logic [TO_WIDTH-1:0] mem_wait_cnt;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        fetch_kill   = (state == REDIR_KILL) && imem_valid;
        if (dmem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ld_use_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_valid || fetch_kill) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // A redirect with no response yet leaves one stale fetch in flight.
    always_comb begin
        state_nxt        = state;
        kill_pending_nxt = kill_pending;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    state_nxt        = MEM_WAIT;
                    kill_pending_nxt = 1'b0;
                end else if (br_taken && !imem_valid) begin
                    state_nxt = REDIR_KILL;
                end
            end
            MEM_WAIT: begin
                if (!dmem_busy) begin
                    kill_pending_nxt = 1'b0;
                    if (kill_pending || (br_taken && !imem_valid))
                        state_nxt = REDIR_KILL;
                    else
                        state_nxt = RUN;
                end
            end
            REDIR_KILL: begin
                if (dmem_busy) begin
                    state_nxt        = MEM_WAIT;
                    kill_pending_nxt = 1'b1;
                end else if (imem_valid) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt        = RUN;
                kill_pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            kill_pending <= 1'b0;
            mem_wait_cnt <= '0;
            stall_cnt    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            kill_pending <= kill_pending_nxt;
            if (!dmem_busy)
                mem_wait_cnt <= '0;
            else if (!(&mem_wait_cnt))
                mem_wait_cnt <= mem_wait_cnt + 1'b1;
            if (dmem_busy && (mem_wait_cnt == TO_LAST))
                timeout_err <= 1'b1;
            if (!pc_write && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
